ftdi_tx_arb: RTL and testbench

//  Round-robin scheduler that shares the single TX byte channel of ftdi_if (tx_din/tx_dv_in/tx_rdy)

---
 rtl/ftdi_tx_arb_pkg.sv | 23 ++
 rtl/ftdi_tx_arb_if.sv | 33 +++
 rtl/ftdi_tx_arb_rr_pick.sv | 36 +++
 rtl/ftdi_tx_arb.sv | 121 ++++++++++++
 tb/tb_ftdi_tx_arb.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ftdi_tx_arb_pkg.sv
// Shared types for the FTDI TX frame arbiter.
// Header layout: {magic nibble, channel index}.
package ftdi_tx_arb_pkg;

  localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    LEN_UNUSED,
    DATA
  } tx_arb_state_t;

  typedef logic [7:0] byte_t;

  function automatic byte_t hdr_byte(
    input logic [3:0] magic,
    input logic [3:0] idx
  );
    return {magic, idx};
  endfunction

endpackage

// File: rtl/ftdi_tx_arb_if.sv
// Requester-side and ftdi_if-side handshakes of the TX arbiter.
// master = arbiter, slave = requesters plus ftdi_if.
interface ftdi_tx_arb_if
  import ftdi_tx_arb_pkg::*;
#(
  parameter int NCH = 4
);

  logic [NCH-1:0]   ch_req;
  logic [NCH*8-1:0] ch_len;
  logic [NCH*8-1:0] ch_din;
  logic [NCH-1:0]   ch_dv;
  logic [NCH-1:0]   ch_rdy;
  logic [NCH-1:0]   ch_gnt;
  byte_t            tx_din;
  logic             tx_dv_in;
  logic             tx_rdy;

  modport master (
    input  ch_req, ch_len, ch_din, ch_dv,
    input  tx_rdy,
    output ch_rdy, ch_gnt,
    output tx_din, tx_dv_in
  );

  modport slave (
    output ch_req, ch_len, ch_din, ch_dv,
    output tx_rdy,
    input  ch_rdy, ch_gnt,
    input  tx_din, tx_dv_in
  );

endinterface

// File: rtl/ftdi_tx_arb_rr_pick.sv
// Combinational round-robin picker: first request at or
// after ptr, searching cyclically.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW:0] s;
  logic        found;

  assign any = |req;

  // Walk N slots from ptr, wrapping once; keep the first hit.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    s          = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (!found && req[s[IW-1:0]]) begin
        found                    = 1'b1;
        gnt_idx                  = s[IW-1:0];
        gnt_onehot[s[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftdi_tx_arb.sv
// Round-robin frame scheduler onto the single ftdi_if TX byte channel.
// Frame = header, length-1 byte, then the payload bytes, never interleaved.
module ftdi_tx_arb
  import ftdi_tx_arb_pkg::*;
#(
  parameter int         NCH       = 4,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ftdi_tx_arb_if.master bus,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  tx_arb_state_t  state_q;
  logic [IW-1:0]  g_q;
  logic [IW-1:0]  rr_ptr_q;
  byte_t          rem_q;
  byte_t          tx_din_q;
  logic           tx_dv_q;
  logic [NCH-1:0] gnt_q;
  logic [15:0]    frame_cnt_q;

  logic [NCH-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic [IW-1:0]  rr_ptr_d;
  logic           can_load;
  logic           src_fire;
  logic [NCH-1:0] rdy_c;
  byte_t          len_a [NCH];
  byte_t          din_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign len_a[i] = bus.ch_len[i*8 +: 8];
    assign din_a[i] = bus.ch_din[i*8 +: 8];
  end

  rr_pick #(
    .N (NCH)
  ) u_pick (
    .req        (bus.ch_req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // Output register can take a byte when empty or draining now.
  assign can_load = !tx_dv_q || bus.tx_rdy;
  assign src_fire = (state_q == DATA) && bus.ch_dv[g_q] && can_load;
  assign rr_ptr_d = (pick_idx == IW'(NCH - 1)) ? '0
                  : pick_idx + 1'b1;

  // Only the granted channel may push payload, and only when it fits.
  always_comb begin
    rdy_c = '0;
    if (state_q == DATA && can_load) rdy_c[g_q] = 1'b1;
  end

  assign bus.ch_rdy   = rdy_c;
  assign bus.ch_gnt   = gnt_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_dv_in = tx_dv_q;
  assign busy         = (state_q != IDLE) || tx_dv_q;
  assign frame_cnt    = frame_cnt_q;

  // Frame FSM with the output byte register and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      rem_q       <= '0;
      tx_din_q    <= '0;
      tx_dv_q     <= 1'b0;
      gnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      gnt_q <= '0;
      if (tx_dv_q && bus.tx_rdy) tx_dv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any && can_load) begin
            g_q      <= pick_idx;
            rem_q    <= len_a[pick_idx];
            tx_din_q <= hdr_byte(HDR_MAGIC, 4'(pick_idx));
            tx_dv_q  <= 1'b1;
            gnt_q    <= pick_oh;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= HDR;
          end
        end
        HDR: begin
          if (can_load) begin
            tx_din_q <= rem_q;
            tx_dv_q  <= 1'b1;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (src_fire) begin
            tx_din_q <= din_a[g_q];
            tx_dv_q  <= 1'b1;
            if (rem_q == 8'd0) begin
              state_q     <= IDLE;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              rem_q <= rem_q - 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arb.sv
// Scoreboard bench for ftdi_tx_arb: expected TX bytes and grants
// are queued at stimulus time and popped as the DUT emits them.
module tb_ftdi_tx_arb;
  import ftdi_tx_arb_pkg::*;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  ftdi_tx_arb_if #(.NCH(NCH)) bus();

  ftdi_tx_arb #(
    .NCH       (NCH),
    .HDR_MAGIC (4'hA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         gnt_exp[$];
  byte_t      src_q[NCH][$];
  int         req_add[NCH];
  int         req_done[NCH];
  logic [NCH-1:0] hold = '0;
  logic [NCH-1:0] src_fire = '0;
  logic       rdy_toggle = 1'b0;
  logic       rdy_level = 1'b1;
  int         tx_count = 0;
  logic       prev_stall = 1'b0;
  byte_t      prev_din = '0;
  logic [8:0] mon_e;
  int         mon_g;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Requester and ftdi_if models, driven just after each edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (src_fire[i] && src_q[i].size() > 0)
        void'(src_q[i].pop_front());
      bus.ch_req[i] = req_add[i] > req_done[i];
      bus.ch_dv[i]  = (src_q[i].size() > 0) && !hold[i];
      bus.ch_din[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    bus.tx_rdy = rdy_toggle ? ~bus.tx_rdy : rdy_level;
  end

  // Monitor on the falling edge: TX bytes, grants, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_dv", 32'(bus.tx_dv_in), 32'd1);
        check("hold_din", 32'(bus.tx_din), 32'(prev_din));
      end
      if (bus.tx_dv_in && bus.tx_rdy) begin
        mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        check("tx_byte", 32'({1'b0, bus.tx_din}), 32'(mon_e));
        tx_count++;
      end
      if (bus.ch_gnt != '0) begin
        mon_g = (gnt_exp.size() > 0) ? (1 << gnt_exp.pop_front()) : 32'hFFFF;
        check("gnt", 32'(bus.ch_gnt), 32'(mon_g));
        for (int i = 0; i < NCH; i++)
          if (bus.ch_gnt[i]) req_done[i]++;
      end
      src_fire   = bus.ch_dv & bus.ch_rdy;
      prev_stall = bus.tx_dv_in && !bus.tx_rdy;
      prev_din   = bus.tx_din;
    end else begin
      src_fire   = '0;
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    hold       = '0;
    rdy_toggle = 1'b0;
    rdy_level  = 1'b1;
    exp_q.delete();
    gnt_exp.delete();
    for (int i = 0; i < NCH; i++) begin
      src_q[i].delete();
      req_add[i] = req_done[i];
    end
    step(2);
    check("rst_dv", 32'(bus.tx_dv_in), 32'd0);
    check("rst_din", 32'(bus.tx_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_gnt", 32'(bus.ch_gnt), 32'd0);
    check("rst_rdy", 32'(bus.ch_rdy), 32'd0);
    rst_n = 1'b1;
    step(1);
  endtask

  // One frame for channel c: payload byte k = base + k*stp.
  task automatic queue_frame(input int c, input int len,
                             input int base, input int stp);
    byte_t b;
    bus.ch_len[c*8 +: 8] = 8'(len);
    gnt_exp.push_back(c);
    exp_q.push_back({1'b0, 4'hA, 4'(c)});
    exp_q.push_back({1'b0, 8'(len)});
    for (int k = 0; k <= len; k++) begin
      b = 8'(base + k * stp);
      exp_q.push_back({1'b0, b});
      src_q[c].push_back(b);
    end
    req_add[c]++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_gnt"}, 32'(gnt_exp.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.ch_len = '0;
    for (int i = 0; i < NCH; i++) begin
      req_add[i]  = 0;
      req_done[i] = 0;
    end

    // Round robin: all four request, channel 0 twice.
    do_reset();
    queue_frame(0, 0, 8'h10, 1);
    queue_frame(1, 0, 8'h20, 1);
    queue_frame(2, 0, 8'h30, 1);
    queue_frame(3, 0, 8'h40, 1);
    queue_frame(0, 0, 8'h50, 1);
    wait_done("rr", 200);
    check("rr_fcnt", 32'(frame_cnt), 32'd5);

    // Single frame with header latency.
    do_reset();
    queue_frame(2, 3, 8'h11, 8'h11);
    step(1);
    check("lat_idle", 32'(bus.tx_dv_in), 32'd0);
    step(1);
    check("lat_dv", 32'(bus.tx_dv_in), 32'd1);
    check("lat_hdr", 32'(bus.tx_din), 32'hA2);
    wait_done("single", 100);
    check("single_fcnt", 32'(frame_cnt), 32'd1);

    // Backpressure: tx_rdy toggles every cycle.
    do_reset();
    rdy_toggle = 1'b1;
    base = tx_count;
    queue_frame(0, 7, 8'h80, 3);
    wait_done("bp", 200);
    check("bp_bytes", 32'(tx_count - base), 32'd10);
    rdy_toggle = 1'b0;

    // Source bubble mid-payload; also change ch_len after grant.
    do_reset();
    queue_frame(1, 7, 8'h40, 1);
    n = 0;
    while (gnt_exp.size() > 0 && n < 50) begin step(1); n++; end
    check("bub_grant", 32'(gnt_exp.size()), 32'd0);
    bus.ch_len[1*8 +: 8] = 8'h02;
    n = 0;
    while (src_q[1].size() > 5 && n < 100) begin step(1); n++; end
    check("bub_wait", 32'(src_q[1].size() <= 5), 32'd1);
    hold[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (k >= 2) check("bub_gap", 32'(bus.tx_dv_in), 32'd0);
      check("bub_state", 32'(dut.state_q), 32'(DATA));
    end
    hold[1] = 1'b0;
    wait_done("bub", 100);
    check("bub_fcnt", 32'(frame_cnt), 32'd1);

    // Maximum length: 256 payload bytes.
    do_reset();
    queue_frame(3, 255, 0, 1);
    wait_done("max", 800);
    check("max_fcnt", 32'(frame_cnt), 32'd1);
    check("max_state", 32'(dut.state_q), 32'(IDLE));

    // Reset mid-frame after two payload bytes.
    do_reset();
    queue_frame(0, 0, 8'h77, 1);
    wait_done("pre", 100);
    check("pre_fcnt", 32'(frame_cnt), 32'd1);
    base = tx_count;
    queue_frame(1, 7, 8'h90, 1);
    n = 0;
    while ((tx_count - base) < 4 && n < 100) begin step(1); n++; end
    check("mid_wait", 32'(tx_count - base), 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_dv", 32'(bus.tx_dv_in), 32'd0);
    check("mid_fcnt", 32'(frame_cnt), 32'd0);
    do_reset();
    queue_frame(2, 0, 8'h5A, 0);
    wait_done("post", 100);
    check("post_fcnt", 32'(frame_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
